// File: rtl/alu_shifter_unit_if.sv
// Execute-stage bus between the control unit and the shifter/ALU datapath.
// master: the control unit / operand buses (drives operands and control, reads result).
// slave : the alu_shifter_unit datapath.
// Signals: op_a, r_in, shift_type, shift_amount, shift_use_rxx, shift_latch_amt,
//          shift_use_latch, carry_in, alu_op, latch_op_b, use_op_b_latch,
//          disable_op_b, flags_in (control -> datapath); result, flags_out (back).
interface alu_shifter_unit_if;
  logic [31:0] op_a;
  logic [31:0] r_in;
  logic [1:0]  shift_type;
  logic [7:0]  shift_amount;
  logic        shift_use_rxx;
  logic        shift_latch_amt;
  logic        shift_use_latch;
  logic        carry_in;
  logic [3:0]  alu_op;
  logic        latch_op_b;
  logic        use_op_b_latch;
  logic        disable_op_b;
  logic [3:0]  flags_in;
  logic [31:0] result;
  logic [3:0]  flags_out;

  modport master (
    output op_a, r_in, shift_type, shift_amount, shift_use_rxx, shift_latch_amt,
           shift_use_latch, carry_in, alu_op, latch_op_b, use_op_b_latch,
           disable_op_b, flags_in,
    input  result, flags_out
  );

  modport slave (
    input  op_a, r_in, shift_type, shift_amount, shift_use_rxx, shift_latch_amt,
           shift_use_latch, carry_in, alu_op, latch_op_b, use_op_b_latch,
           disable_op_b, flags_in,
    output result, flags_out
  );
endinterface

// File: rtl/alu_shifter_unit.sv
// ARM7TDMI-style execute datapath: barrel shifter feeding a 32-bit
// data-processing ALU. Purely combinational apart from two small latches:
// the register-specified shift count and the operand-B {carry,value} latch.
// Ports:
//   clk      - system clock, latches update on posedge
//   reset_n  - asynchronous active-low reset, clears both latches
//   bus      - alu_shifter_unit_if.slave: operands, shift/ALU control,
//              flags_in (CPSR NZCV), result and flags_out {N,Z,C,V}
module alu_shifter_unit (
  input logic             clk,
  input logic             reset_n,
  alu_shifter_unit_if.slave bus
);

  localparam logic [1:0] SH_LSL = 2'd0;
  localparam logic [1:0] SH_LSR = 2'd1;
  localparam logic [1:0] SH_ASR = 2'd2;
  localparam logic [1:0] SH_ROR = 2'd3;

  localparam logic [3:0] OP_AND = 4'd0,  OP_EOR = 4'd1,  OP_SUB = 4'd2,  OP_RSB = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4,  OP_ADC = 4'd5,  OP_SBC = 4'd6,  OP_RSC = 4'd7;
  localparam logic [3:0] OP_TST = 4'd8,  OP_TEQ = 4'd9,  OP_CMP = 4'd10, OP_CMN = 4'd11;
  localparam logic [3:0] OP_ORR = 4'd12, OP_MOV = 4'd13, OP_BIC = 4'd14, OP_MVN = 4'd15;

  // 33-bit add returning {V, C, sum}; V is signed overflow of a + b + cin.
  function automatic logic [33:0] add33(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin);
    logic [32:0]        s;
    logic signed [31:0] sa, sb, ss;
    logic               v;
    s  = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    sa = a;
    sb = b;
    ss = s[31:0];
    v  = ((sa < 0) == (sb < 0)) && ((ss < 0) != (sa < 0));
    return {v, s};
  endfunction

  logic [7:0]  amt_latch;
  logic [31:0] opb_latch;
  logic        opb_latch_c;

  logic [7:0]         amt;
  logic [31:0]        sh_val;
  logic               sh_c;
  logic [32:0]        lsl_t;
  logic [32:0]        lsr_t;
  logic signed [32:0] asr_src;
  logic [32:0]        asr_t;
  logic [63:0]        ror_t;

  // Latch stage: values captured here are seen by the datapath next cycle,
  // so a same-cycle capture and use reads the old contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      amt_latch   <= 8'd0;
      opb_latch   <= 32'd0;
      opb_latch_c <= 1'b0;
    end else begin
      if (bus.shift_latch_amt)
        amt_latch <= bus.r_in[7:0];
      if (bus.latch_op_b) begin
        opb_latch   <= sh_val;
        opb_latch_c <= sh_c;
      end
    end
  end

  // Barrel shifter. Each shift form carries one extra bit so the last bit
  // shifted out falls out as the carry without a variable bit select.
  always_comb begin
    amt     = bus.shift_use_latch ? amt_latch : bus.shift_amount;
    lsl_t   = {1'b0, bus.r_in} << amt[4:0];
    lsr_t   = {bus.r_in, 1'b0} >> amt[4:0];
    asr_src = {bus.r_in, 1'b0};
    asr_t   = asr_src >>> amt[4:0];
    ror_t   = {bus.r_in, bus.r_in} >> amt[4:0];
    sh_val  = bus.r_in;
    sh_c    = bus.carry_in;
    if (bus.shift_use_rxx) begin
      sh_val = {bus.carry_in, bus.r_in[31:1]};
      sh_c   = bus.r_in[0];
    end else if (amt != 8'd0) begin
      unique case (bus.shift_type)
        SH_LSL: begin
          if (amt < 8'd32) begin
            sh_val = lsl_t[31:0];
            sh_c   = lsl_t[32];
          end else begin
            sh_val = 32'd0;
            sh_c   = (amt == 8'd32) ? bus.r_in[0] : 1'b0;
          end
        end
        SH_LSR: begin
          if (amt < 8'd32) begin
            sh_val = lsr_t[32:1];
            sh_c   = lsr_t[0];
          end else begin
            sh_val = 32'd0;
            sh_c   = (amt == 8'd32) ? bus.r_in[31] : 1'b0;
          end
        end
        SH_ASR: begin
          if (amt < 8'd32) begin
            sh_val = asr_t[32:1];
            sh_c   = asr_t[0];
          end else begin
            sh_val = {32{bus.r_in[31]}};
            sh_c   = bus.r_in[31];
          end
        end
        SH_ROR: begin
          // A multiple of 32 leaves the value intact and still yields r_in[31]
          // as carry, which the rotate form produces naturally.
          sh_val = ror_t[31:0];
          sh_c   = ror_t[31];
        end
        default: begin
          sh_val = bus.r_in;
          sh_c   = bus.carry_in;
        end
      endcase
    end
  end

  logic [31:0] op_b;
  logic        op_b_c;
  logic [31:0] res;
  logic        c_out;
  logic        v_out;
  logic        known_op;
  logic [33:0] sum;

  // ALU: the disable path zeroes the value but keeps carry_in as shifter carry.
  always_comb begin
    if (bus.disable_op_b) begin
      op_b   = 32'd0;
      op_b_c = bus.carry_in;
    end else if (bus.use_op_b_latch) begin
      op_b   = opb_latch;
      op_b_c = opb_latch_c;
    end else begin
      op_b   = sh_val;
      op_b_c = sh_c;
    end

    sum      = 34'd0;
    res      = 32'd0;
    c_out    = op_b_c;
    v_out    = bus.flags_in[0];
    known_op = 1'b1;
    case (bus.alu_op)
      OP_AND, OP_TST: res = bus.op_a & op_b;
      OP_EOR, OP_TEQ: res = bus.op_a ^ op_b;
      OP_ORR:         res = bus.op_a | op_b;
      OP_MOV:         res = op_b;
      OP_BIC:         res = bus.op_a & ~op_b;
      OP_MVN:         res = ~op_b;
      OP_SUB, OP_CMP: sum = add33(bus.op_a, ~op_b, 1'b1);
      OP_RSB:         sum = add33(op_b, ~bus.op_a, 1'b1);
      OP_ADD, OP_CMN: sum = add33(bus.op_a, op_b, 1'b0);
      OP_ADC:         sum = add33(bus.op_a, op_b, bus.flags_in[1]);
      OP_SBC:         sum = add33(bus.op_a, ~op_b, bus.flags_in[1]);
      OP_RSC:         sum = add33(op_b, ~bus.op_a, bus.flags_in[1]);
      default:        known_op = 1'b0;
    endcase

    case (bus.alu_op)
      OP_SUB, OP_CMP, OP_RSB, OP_ADD, OP_CMN, OP_ADC, OP_SBC, OP_RSC: begin
        res   = sum[31:0];
        c_out = sum[32];
        v_out = sum[33];
      end
      default: ;
    endcase

    if (known_op) begin
      bus.result    = res;
      bus.flags_out = {res[31], (res == 32'd0), c_out, v_out};
    end else begin
      bus.result    = 32'd0;
      bus.flags_out = bus.flags_in;
    end
  end

endmodule

// File: tb/tb_alu_shifter_unit.sv
module tb_alu_shifter_unit;
  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  alu_shifter_unit_if bus ();

  alu_shifter_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [3:0] AND_ = 4'd0,  EOR_ = 4'd1,  SUB_ = 4'd2,  RSB_ = 4'd3;
  localparam logic [3:0] ADD_ = 4'd4,  ADC_ = 4'd5,  SBC_ = 4'd6,  RSC_ = 4'd7;
  localparam logic [3:0] TEQ_ = 4'd9,  CMP_ = 4'd10, CMN_ = 4'd11;
  localparam logic [3:0] MOV_ = 4'd13, BIC_ = 4'd14, MVN_ = 4'd15;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.op_a = 0; bus.r_in = 0; bus.shift_type = 0; bus.shift_amount = 0;
    bus.shift_use_rxx = 0; bus.shift_latch_amt = 0; bus.shift_use_latch = 0;
    bus.carry_in = 0; bus.alu_op = MOV_; bus.latch_op_b = 0; bus.use_op_b_latch = 0;
    bus.disable_op_b = 0; bus.flags_in = 0;
  endtask

  // Drive one combinational operation at the falling edge and check it 1 ns later.
  task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] r, input logic [1:0] st, input logic [7:0] am,
                     input logic ci, input logic [3:0] fi,
                     input logic [31:0] er, input logic [3:0] ef);
    @(negedge clk);
    bus.alu_op = op; bus.op_a = a; bus.r_in = r; bus.shift_type = st;
    bus.shift_amount = am; bus.carry_in = ci; bus.flags_in = fi;
    #1;
    chk({tag, "_res"}, bus.result, er);
    chk({tag, "_nzcv"}, {28'd0, bus.flags_out}, {28'd0, ef});
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle();
    reset_n = 1'b0;

    // Reset state: both latches read back as zero.
    @(negedge clk);
    bus.use_op_b_latch = 1; bus.alu_op = MOV_;
    #1;
    chk("rst_opb_res", bus.result, 32'h0);
    chk("rst_opb_nzcv", {28'd0, bus.flags_out}, 32'h4);
    bus.use_op_b_latch = 0; bus.shift_use_latch = 1; bus.r_in = 32'h5; bus.carry_in = 1;
    #1;
    chk("rst_amt_res", bus.result, 32'h5);
    chk("rst_amt_nzcv", {28'd0, bus.flags_out}, 32'h2);
    idle();
    @(negedge clk);
    reset_n = 1'b1;

    run("add_wrap", ADD_, 32'hFFFFFFFF, 32'h1, 2'd0, 8'd0, 0, 4'h0, 32'h0, 4'b0110);
    run("sub_ovf",  SUB_, 32'h80000000, 32'h1, 2'd0, 8'd0, 0, 4'h0, 32'h7FFFFFFF, 4'b0011);
    run("lsr32",    MOV_, 32'h0, 32'h80000000, 2'd1, 8'd32, 0, 4'h1, 32'h0, 4'b0111);
    run("lsl32",    MOV_, 32'h0, 32'h00000001, 2'd0, 8'd32, 0, 4'h0, 32'h0, 4'b0110);
    run("lsl33",    MOV_, 32'h0, 32'hFFFFFFFF, 2'd0, 8'd33, 1, 4'h0, 32'h0, 4'b0100);
    run("asr40",    MOV_, 32'h0, 32'h80000000, 2'd2, 8'd40, 0, 4'h0, 32'hFFFFFFFF, 4'b1010);
    run("ror32",    MOV_, 32'h0, 32'h80000001, 2'd3, 8'd32, 0, 4'h0, 32'h80000001, 4'b1010);
    run("ror4",     MOV_, 32'h0, 32'h0000000F, 2'd3, 8'd4, 0, 4'h0, 32'hF0000000, 4'b1010);
    run("rsb",      RSB_, 32'h1, 32'h3, 2'd0, 8'd0, 0, 4'h0, 32'h2, 4'b0010);
    run("rsc",      RSC_, 32'h1, 32'h3, 2'd0, 8'd0, 0, 4'h0, 32'h1, 4'b0010);
    run("sbc",      SBC_, 32'h0, 32'h1, 2'd0, 8'd0, 0, 4'h2, 32'hFFFFFFFF, 4'b1000);
    run("cmn_ovf",  CMN_, 32'h7FFFFFFF, 32'h1, 2'd0, 8'd0, 0, 4'h0, 32'h80000000, 4'b1001);
    run("cmp_eq",   CMP_, 32'h5, 32'h5, 2'd0, 8'd0, 0, 4'h0, 32'h0, 4'b0110);
    run("bic",      BIC_, 32'hF0F0, 32'hFF00, 2'd0, 8'd0, 0, 4'h0, 32'h00F0, 4'b0000);
    run("teq_v",    TEQ_, 32'h1234, 32'h1234, 2'd0, 8'd0, 0, 4'h1, 32'h0, 4'b0101);
    run("mvn",      MVN_, 32'h1234, 32'h0, 2'd0, 8'd0, 0, 4'h0, 32'hFFFFFFFF, 4'b1000);
    run("and_lslc", AND_, 32'hFFFFFFFF, 32'h80000001, 2'd0, 8'd1, 0, 4'h0, 32'h2, 4'b0010);
    run("eor",      EOR_, 32'hFF00FF00, 32'h0FF00FF0, 2'd0, 8'd0, 0, 4'h0, 32'hF0F0F0F0, 4'b1000);

    // ADC with operand B disabled: 7 + 0 + C.
    @(negedge clk);
    bus.disable_op_b = 1;
    run("adc_dis",  ADC_, 32'h7, 32'hFFFF, 2'd0, 8'd0, 0, 4'h2, 32'h8, 4'b0000);
    bus.disable_op_b = 0;

    // RRX.
    bus.shift_use_rxx = 1;
    run("rrx",      MOV_, 32'h0, 32'h3, 2'd0, 8'd0, 1, 4'h0, 32'h80000001, 4'b1010);
    bus.shift_use_rxx = 0;

    // Register-specified shift count: capture, then use next cycle.
    @(negedge clk);
    idle();
    bus.r_in = 32'h00000104; bus.shift_latch_amt = 1;
    @(negedge clk);
    bus.shift_latch_amt = 0; bus.r_in = 32'h0000000F; bus.shift_type = 2'd0;
    bus.shift_use_latch = 1; bus.alu_op = MOV_;
    #1;
    chk("lat_amt_res", bus.result, 32'h000000F0);
    chk("lat_amt_nzcv", {28'd0, bus.flags_out}, 32'h0);

    // Operand-B latch: capture 0x10, then ADD 5.
    @(negedge clk);
    idle();
    bus.r_in = 32'h10; bus.latch_op_b = 1; bus.alu_op = ADD_; bus.op_a = 32'h5;
    @(negedge clk);
    bus.latch_op_b = 0; bus.r_in = 32'h0; bus.use_op_b_latch = 1;
    #1;
    chk("lat_opb", bus.result, 32'h15);
    // Capture and use in the same cycle sees the old latch.
    bus.latch_op_b = 1; bus.use_op_b_latch = 1; bus.r_in = 32'hAB;
    #1;
    chk("lat_same_cyc", bus.result, 32'h15);
    @(negedge clk);
    bus.latch_op_b = 0;
    #1;
    chk("lat_new", bus.result, 32'hB0);
    // Asynchronous reset mid-sequence, between clock edges.
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    #1;
    chk("lat_after_rst", bus.result, 32'h5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
